// File: rtl/mem_request_unit.sv
// Memory request sequencer: data load/store then instruction fetch over one bus, holding halt.
// Optional bus-wait timeout with sticky bus_error is enabled by defining MEM_TIMEOUT_EN.
module mem_request_unit #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                new_cycle,
  input  logic                fetch_en,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic                halt,
  output logic [DATA_W-1:0]   instruction,
  output logic [DATA_W-1:0]   read_data,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_ben,
  output logic                bus_read,
  output logic                bus_write,
  input  logic                bus_busy,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_error
);

  localparam int unsigned BenW = DATA_W / 8;

  typedef enum logic [2:0] {
    StIdle,
    StDataReq,
    StDataWait,
    StFetchReq,
    StFetchWait,
    StDone
  } state_e;

  state_e              r_state;
  logic                r_halt;
  logic                r_bus_read;
  logic                r_bus_write;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [BenW-1:0]     r_bus_ben;
  logic [DATA_W-1:0]   r_instruction;
  logic [DATA_W-1:0]   r_read_data;
  logic                r_is_read;
  logic                w_timeout;
  logic                w_done;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] r_wait_cnt;
  logic            r_bus_error;

  // Abort on the TIMEOUT_CYCLES-th busy clock of a wait.
  assign w_timeout = bus_busy && (r_state == StDataWait || r_state == StFetchWait) &&
                     (r_wait_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (r_state == StDataReq || r_state == StFetchReq) begin
        r_wait_cnt <= '0;
      end else if ((r_state == StDataWait || r_state == StFetchWait) && bus_busy) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_bus_error <= 1'b1;
      end
    end
  end

  assign bus_error = r_bus_error;
`else
  assign w_timeout = 1'b0;
  assign bus_error = 1'b0;
`endif

  assign w_done = !bus_busy || w_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_halt        <= 1'b0;
      r_bus_read    <= 1'b0;
      r_bus_write   <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_bus_ben     <= '0;
      r_instruction <= '0;
      r_read_data   <= '0;
      r_is_read     <= 1'b0;
    end else begin
      // Strobes are single-clock pulses, raised on the edge entering a REQ state.
      r_bus_read  <= 1'b0;
      r_bus_write <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (new_cycle) begin
            if (data_read || data_write) begin
              r_state     <= StDataReq;
              r_halt      <= 1'b1;
              r_bus_addr  <= data_addr;
              r_bus_ben   <= byte_en;
              r_bus_wdata <= write_data;
              r_bus_write <= data_write;
              r_bus_read  <= !data_write;
              r_is_read   <= !data_write;
            end else if (fetch_en) begin
              r_state    <= StFetchReq;
              r_halt     <= 1'b1;
              r_bus_addr <= pc;
              r_bus_ben  <= '1;
              r_bus_read <= 1'b1;
            end
          end
        end
        StDataReq: r_state <= StDataWait;
        StDataWait: begin
          if (w_done) begin
            if (r_is_read) begin
              r_read_data <= w_timeout ? '0 : bus_rdata;
            end
            if (fetch_en) begin
              r_state    <= StFetchReq;
              r_bus_addr <= pc;
              r_bus_ben  <= '1;
              r_bus_read <= 1'b1;
            end else begin
              r_state <= StDone;
            end
          end
        end
        StFetchReq: r_state <= StFetchWait;
        StFetchWait: begin
          if (w_done) begin
            r_instruction <= w_timeout ? '0 : bus_rdata;
            r_state       <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_halt  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  assign halt        = r_halt;
  assign bus_read    = r_bus_read;
  assign bus_write   = r_bus_write;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_ben     = r_bus_ben;
  assign instruction = r_instruction;
  assign read_data   = r_read_data;

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit; bus_busy/bus_rdata are driven step by step.
// The timeout section runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_request_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        new_cycle;
  logic        fetch_en;
  logic [31:0] pc;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic [3:0]  byte_en;
  logic        halt;
  logic [31:0] instruction;
  logic [31:0] read_data;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_ben;
  logic        bus_read;
  logic        bus_write;
  logic        bus_busy;
  logic [31:0] bus_rdata;
  logic        bus_error;

  int errors = 0;
  int checks = 0;
  int halt_cnt;
  int rd_cnt;
  int wr_cnt;

  mem_request_unit #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .new_cycle(new_cycle),
    .fetch_en(fetch_en),
    .pc(pc),
    .data_read(data_read),
    .data_write(data_write),
    .data_addr(data_addr),
    .write_data(write_data),
    .byte_en(byte_en),
    .halt(halt),
    .instruction(instruction),
    .read_data(read_data),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ben(bus_ben),
    .bus_read(bus_read),
    .bus_write(bus_write),
    .bus_busy(bus_busy),
    .bus_rdata(bus_rdata),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (halt) halt_cnt++;
    if (bus_read) rd_cnt++;
    if (bus_write) wr_cnt++;
  endtask

  task automatic clr_counts();
    halt_cnt = 0;
    rd_cnt   = 0;
    wr_cnt   = 0;
  endtask

  initial begin
    reset      = 1'b1;
    new_cycle  = 1'b0;
    fetch_en   = 1'b0;
    pc         = '0;
    data_read  = 1'b0;
    data_write = 1'b0;
    data_addr  = '0;
    write_data = '0;
    byte_en    = '0;
    bus_busy   = 1'b0;
    bus_rdata  = '0;
    clr_counts();
    tick();
    tick();
    chk("rst_halt", halt, 0);
    chk("rst_rd", bus_read, 0);
    chk("rst_wr", bus_write, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_err", bus_error, 0);
    reset = 1'b0;
    tick();

    // new_cycle with nothing requested stays idle
    new_cycle = 1'b1;
    tick();
    new_cycle = 1'b0;
    chk("idle_nop_halt", halt, 0);
    tick();
    chk("idle_nop_halt2", halt, 0);

    // Fetch only, zero-wait
    clr_counts();
    fetch_en  = 1'b1;
    pc        = 32'h100;
    bus_rdata = 32'h0050_0093;
    new_cycle = 1'b1;
    tick();
    new_cycle = 1'b0;
    chk("f1_halt", halt, 1);
    chk("f1_rd", bus_read, 1);
    chk("f1_wr", bus_write, 0);
    chk("f1_addr", bus_addr, 32'h100);
    chk("f1_ben", bus_ben, 4'hF);
    tick();
    chk("f1_rd_low", bus_read, 0);
    tick();
    chk("f1_instr", instruction, 32'h0050_0093);
    tick();
    chk("f1_halt_end", halt, 0);
    chk("f1_halt_cnt", halt_cnt, 3);
    chk("f1_rd_cnt", rd_cnt, 1);

    // Reset mid-FETCH_WAIT
    pc        = 32'h200;
    bus_busy  = 1'b1;
    new_cycle = 1'b1;
    tick();
    new_cycle = 1'b0;
    tick();
    chk("mr_halt_pre", halt, 1);
    reset = 1'b1;
    #1;
    chk("mr_halt", halt, 0);
    chk("mr_rd", bus_read, 0);
    chk("mr_instr", instruction, 0);
    #2;
    reset    = 1'b0;
    bus_busy = 1'b0;
    tick();
    chk("mr_idle", halt, 0);
    pc        = 32'h300;
    bus_rdata = 32'h1111_1111;
    new_cycle = 1'b1;
    tick();
    new_cycle = 1'b0;
    chk("mr_fresh_rd", bus_read, 1);
    chk("mr_fresh_addr", bus_addr, 32'h300);
    tick();
    tick();
    chk("mr_fresh_instr", instruction, 32'h1111_1111);
    tick();
    chk("mr_fresh_halt", halt, 0);

    // Read then fetch, two busy clocks on each access
    clr_counts();
    data_read = 1'b1;
    data_addr = 32'h2000;
    byte_en   = 4'hF;
    fetch_en  = 1'b1;
    pc        = 32'h104;
    new_cycle = 1'b1;
    tick();
    new_cycle = 1'b0;
    chk("rf_drd", bus_read, 1);
    chk("rf_daddr", bus_addr, 32'h2000);
    bus_busy = 1'b1;
    tick();
    chk("rf_dwait_rd", bus_read, 0);
    tick();
    tick();
    bus_busy  = 1'b0;
    bus_rdata = 32'hCAFE_F00D;
    tick();
    chk("rf_rdata", read_data, 32'hCAFE_F00D);
    chk("rf_frd", bus_read, 1);
    chk("rf_faddr", bus_addr, 32'h104);
    bus_busy = 1'b1;
    tick();
    tick();
    tick();
    bus_busy  = 1'b0;
    bus_rdata = 32'h00A0_0113;
    tick();
    chk("rf_instr", instruction, 32'h00A0_0113);
    chk("rf_halt_done", halt, 1);
    tick();
    chk("rf_halt_end", halt, 0);
    chk("rf_halt_cnt", halt_cnt, 9);
    chk("rf_rd_cnt", rd_cnt, 2);
    chk("rf_rdata_keep", read_data, 32'hCAFE_F00D);

    // Read+write together acts as a write
    clr_counts();
    data_write = 1'b1;
    data_read  = 1'b1;
    data_addr  = 32'h3000;
    write_data = 32'hDEAD_BEEF;
    byte_en    = 4'h3;
    fetch_en   = 1'b0;
    bus_rdata  = 32'h5555_5555;
    new_cycle  = 1'b1;
    tick();
    new_cycle = 1'b0;
    chk("rw_wr", bus_write, 1);
    chk("rw_rd", bus_read, 0);
    chk("rw_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("rw_ben", bus_ben, 4'h3);
    chk("rw_addr", bus_addr, 32'h3000);
    tick();
    tick();
    tick();
    chk("rw_halt_end", halt, 0);
    chk("rw_rdata_keep", read_data, 32'hCAFE_F00D);
    chk("rw_halt_cnt", halt_cnt, 3);
    chk("rw_wr_cnt", wr_cnt, 1);
    chk("rw_rd_cnt", rd_cnt, 0);
    data_write = 1'b0;
    data_read  = 1'b0;

    // new_cycle held high while halted is ignored
    clr_counts();
    fetch_en  = 1'b1;
    pc        = 32'h400;
    bus_rdata = 32'h0000_0077;
    new_cycle = 1'b1;
    tick();
    tick();
    tick();
    new_cycle = 1'b0;
    tick();
    tick();
    chk("nc_halt", halt, 0);
    chk("nc_rd_cnt", rd_cnt, 1);
    chk("nc_halt_cnt", halt_cnt, 3);
    chk("nc_instr", instruction, 32'h0000_0077);
    chk("nc_err", bus_error, 0);

`ifdef MEM_TIMEOUT_EN
    // Fetch with bus stuck busy aborts after four wait clocks
    clr_counts();
    pc        = 32'h500;
    bus_busy  = 1'b1;
    new_cycle = 1'b1;
    tick();
    new_cycle = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("to_err_pre", bus_error, 0);
    tick();
    chk("to_err", bus_error, 1);
    chk("to_instr", instruction, 0);
    chk("to_halt_done", halt, 1);
    tick();
    chk("to_halt_end", halt, 0);
    chk("to_halt_cnt", halt_cnt, 6);
    tick();
    chk("to_err_sticky", bus_error, 1);
    reset = 1'b1;
    #1;
    chk("to_err_rst", bus_error, 0);
    #2;
    reset    = 1'b0;
    bus_busy = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Sits directly upstream of the clock controller and generates its `halt` input.
- On each CPU instruction cycle, performs the pending data load/store, then the instruction fetch, over a single external memory bus.
- Keeps `halt` asserted until both accesses complete, so the gated CPU clock is frozen while memory is busy.
- Runs on the free-running system clock, not the gated CPU clock.

Parameters:
ADDR_W, 32, width of address buses
DATA_W, 32, width of data buses and instruction word
TIMEOUT_CYCLES, 255, bus-wait limit in clocks (used only with MEM_TIMEOUT_EN)

Ports:
clock  input  1  free-running system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
new_cycle  input  1  one-clock pulse marking the start of a CPU instruction cycle
fetch_en  input  1  an instruction fetch is required this cycle
pc  input  ADDR_W  fetch address
data_read  input  1  load requested
data_write  input  1  store requested
data_addr  input  ADDR_W  load/store address
write_data  input  DATA_W  store data
byte_en  input  DATA_W/8  store/load byte enables
halt  output  1  registered; high while a memory sequence is in progress
instruction  output  DATA_W  last fetched instruction
read_data  output  DATA_W  last load result
bus_addr  output  ADDR_W  registered bus address
bus_wdata  output  DATA_W  registered bus write data
bus_ben  output  DATA_W/8  registered bus byte enables
bus_read  output  1  one-clock read strobe
bus_write  output  1  one-clock write strobe
bus_busy  input  1  high while the bus is servicing a strobe
bus_rdata  input  DATA_W  bus read data; valid when bus_busy is low in a WAIT state
bus_error  output  1  sticky timeout flag (see Optional Feature)

Behaviour:
- Reset values (async, immediate): state IDLE; halt=0; bus_read=0; bus_write=0; bus_addr=0; bus_wdata=0; bus_ben=0; instruction=0; read_data=0; bus_error=0.
- FSM states: IDLE, DATA_REQ, DATA_WAIT, FETCH_REQ, FETCH_WAIT, DONE.
- halt is registered: it is 1 in every state except IDLE, so it rises on the edge that leaves IDLE and falls on the edge DONE->IDLE.
- IDLE transitions, sampled only when new_cycle=1:
  - data_read or data_write -> DATA_REQ.
  - else fetch_en -> FETCH_REQ.
  - else stay in IDLE; halt stays 0.
- new_cycle is ignored in every state other than IDLE.
- DATA_REQ (1 clock):
  - Drive bus_addr=data_addr, bus_ben=byte_en, bus_wdata=write_data.
  - Strobe bus_write if data_write, otherwise bus_read.
  - If data_read and data_write are both high, the access is a write and read_data is unchanged.
  - Next state: DATA_WAIT.
- DATA_WAIT:
  - Strobes are low; bus_busy is first sampled in this state.
  - Stay while bus_busy=1.
  - When bus_busy=0: for a read, latch bus_rdata into read_data. Then go to FETCH_REQ if fetch_en, else DONE.
- FETCH_REQ (1 clock): bus_addr=pc, bus_ben=all ones, bus_read strobe. Next state: FETCH_WAIT.
- FETCH_WAIT: stay while bus_busy=1; when bus_busy=0, latch bus_rdata into instruction and go to DONE.
- DONE (1 clock): go to IDLE.
- Latency with a zero-wait bus (bus_busy=0):
  - Fetch only: halt high for exactly 3 clocks.
  - Data access only: 3 clocks.
  - Data access + fetch: 5 clocks.
  - Each bus wait cycle adds one clock.
- CPU-side inputs are held stable by the frozen CPU clock while halt=1 and are re-sampled only in the REQ states.
- Reset mid-sequence: strobes and halt drop immediately, FSM returns to IDLE, instruction and read_data are cleared, and the interrupted access is abandoned.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to DATA_WAIT or FETCH_WAIT and increments each clock bus_busy=1.
  - When it reaches TIMEOUT_CYCLES, the access is aborted: bus_error sets (sticky until reset), the target register (read_data or instruction) is loaded with 0, and the FSM proceeds exactly as on normal completion.
- Undefined: no counter; WAIT states wait indefinitely; bus_error is tied to 0.

Test Plan:
- Reset asserted mid-FETCH_WAIT -> halt=0, bus_read=0, instruction=0 immediately; the next new_cycle starts a fresh sequence.
- new_cycle with fetch_en=1, pc=0x100, bus_rdata=0x00500093, zero-wait bus -> one bus_read at 0x100 with ben=F; halt high exactly 3 clocks; instruction=0x00500093.
- new_cycle with data_read=1, data_addr=0x2000, fetch_en=1, bus_busy high for 2 clocks on each access -> read then fetch, in that order; halt high 9 clocks; read_data and instruction latched correctly.
- new_cycle with data_write=1 and data_read=1, write_data=0xDEADBEEF, byte_en=0x3 -> single bus_write with wdata=0xDEADBEEF and ben=0x3; read_data unchanged.
- new_cycle pulsed again while halt=1 -> ignored; exactly one sequence executes.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus_busy stuck at 1 during fetch -> abort after 4 wait clocks; bus_error=1; instruction=0; halt falls; bus_error stays 1 until reset.
